// File: rtl/riscv_mc_pkg.sv
// riscv_mc_pkg
// Shared definitions for the multicycle RV64I core: memory and register-file
// sizes, the control FSM state encoding, major opcodes, the ALU operation
// encoding and the opcode decoder used by the control FSM.
package riscv_mc_pkg;

    localparam int XLEN       = 64;
    localparam int IMEM_WORDS = 64;
    localparam int DMEM_WORDS = 32;
    localparam int NUM_REGS   = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        START,
        FETCH,
        DECODE,
        LOAD_STORE,
        LOAD,
        LOAD_DONE,
        LOAD_IDLE,
        STORE,
        RTYPE,
        ITYPE,
        ALU_WB,
        BRANCH,
        HALT
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR
    } alu_op_t;

    // State that follows DECODE for a given instruction word. An all-zero
    // word halts; an unrecognised opcode is skipped (back to FETCH).
    function automatic state_t decode_next(input logic [31:0] instr);
        state_t nxt;
        if (instr == 32'd0) begin
            nxt = HALT;
        end else begin
            case (instr[6:0])
                OP_LOAD, OP_STORE: nxt = LOAD_STORE;
                OP_RTYPE:          nxt = RTYPE;
                OP_ITYPE:          nxt = ITYPE;
                OP_BRANCH:         nxt = BRANCH;
                default:           nxt = FETCH;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/riscv_mc_control.sv
// riscv_mc_control
// Control FSM of the multicycle core. Every strobe is registered: it is
// computed on the transition into a state and is therefore valid for the
// whole cycle spent in that state.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   run, power        start request / enable, only looked at in START
//   fetch_instr       IMEM word at the current PC (becomes the IR after FETCH)
//   instr             instruction register
//   alu_zero          ALU result is zero (branch compare)
//   state             current FSM state
//   startpc..pcsrc    datapath strobes; alu_op selects the ALU operation
module riscv_mc_control
    import riscv_mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        power,
    input  logic [31:0] fetch_instr,
    input  logic [31:0] instr,
    input  logic        alu_zero,
    output logic [3:0]  state,
    output logic        startpc,
    output logic        writepc,
    output logic        alusrc,
    output logic [1:0]  alu_op,
    output logic        memread,
    output logic        memwrite,
    output logic        regwrite,
    output logic        mem2reg,
    output logic        pcsrc
);

    state_t  state_reg;
    alu_op_t alu_op_reg;
    // Set during the first of the two BRANCH cycles: the compare result is
    // registered into pcsrc, and the PC is updated in the second cycle.
    logic    branch_cmp_reg;
    state_t  decode_state;
    state_t  fetch_state;

    assign decode_state = decode_next(instr);
    // Lets the skip of an unknown opcode update the PC during DECODE itself.
    assign fetch_state  = decode_next(fetch_instr);
    assign state        = state_reg;
    assign alu_op       = alu_op_reg;

    // Unsupported funct combinations fall back to add.
    function automatic alu_op_t rtype_op(input logic [31:0] w);
        alu_op_t op;
        if (w[31:25] == 7'b0100000 && w[14:12] == 3'b000)
            op = ALU_SUB;
        else if (w[31:25] == 7'b0000000 && w[14:12] == 3'b111)
            op = ALU_AND;
        else if (w[31:25] == 7'b0000000 && w[14:12] == 3'b110)
            op = ALU_OR;
        else
            op = ALU_ADD;
        return op;
    endfunction

    function automatic alu_op_t itype_op(input logic [31:0] w);
        alu_op_t op;
        case (w[14:12])
            3'b111:  op = ALU_AND;
            3'b110:  op = ALU_OR;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= START;
            alu_op_reg     <= ALU_ADD;
            branch_cmp_reg <= 1'b0;
            startpc        <= 1'b0;
            writepc        <= 1'b0;
            alusrc         <= 1'b0;
            memread        <= 1'b0;
            memwrite       <= 1'b0;
            regwrite       <= 1'b0;
            mem2reg        <= 1'b0;
            pcsrc          <= 1'b0;
        end else begin
            alu_op_reg <= ALU_ADD;
            startpc    <= 1'b0;
            writepc    <= 1'b0;
            alusrc     <= 1'b0;
            memread    <= 1'b0;
            memwrite   <= 1'b0;
            regwrite   <= 1'b0;
            mem2reg    <= 1'b0;
            pcsrc      <= 1'b0;
            case (state_reg)
                START: begin
                    if (run && power) begin
                        state_reg <= FETCH;
                    end else begin
                        startpc <= 1'b1;
                        writepc <= 1'b1;
                    end
                end
                FETCH: begin
                    state_reg <= DECODE;
                    writepc   <= (fetch_state == FETCH);
                end
                DECODE: begin
                    state_reg <= decode_state;
                    case (decode_state)
                        LOAD_STORE: alusrc <= 1'b1;
                        RTYPE:      alu_op_reg <= rtype_op(instr);
                        ITYPE: begin
                            alusrc     <= 1'b1;
                            alu_op_reg <= itype_op(instr);
                        end
                        BRANCH:     alu_op_reg <= ALU_SUB;
                        default: ;
                    endcase
                end
                LOAD_STORE: begin
                    // Address (rs1 + imm) must stay on the ALU for the access cycle.
                    alusrc <= 1'b1;
                    if (instr[6:0] == OP_LOAD) begin
                        state_reg <= LOAD;
                        memread   <= 1'b1;
                    end else begin
                        state_reg <= STORE;
                        memwrite  <= 1'b1;
                        writepc   <= 1'b1;
                    end
                end
                LOAD: begin
                    state_reg <= LOAD_DONE;
                    regwrite  <= 1'b1;
                    mem2reg   <= 1'b1;
                end
                LOAD_DONE: begin
                    state_reg <= LOAD_IDLE;
                    writepc   <= 1'b1;
                end
                LOAD_IDLE, STORE, ALU_WB: state_reg <= FETCH;
                RTYPE, ITYPE: begin
                    state_reg  <= ALU_WB;
                    alu_op_reg <= alu_op_reg;
                    alusrc     <= (state_reg == ITYPE);
                    regwrite   <= 1'b1;
                    writepc    <= 1'b1;
                end
                BRANCH: begin
                    if (!branch_cmp_reg) begin
                        branch_cmp_reg <= 1'b1;
                        writepc        <= 1'b1;
                        pcsrc          <= alu_zero;
                    end else begin
                        branch_cmp_reg <= 1'b0;
                        state_reg      <= FETCH;
                    end
                end
                HALT:    state_reg <= HALT;
                default: state_reg <= START;
            endcase
        end
    end

endmodule

// File: rtl/riscv_multicycle_core.sv
// riscv_multicycle_core
// Multicycle RV64I-subset core (ld, sd, add/sub/and/or, addi/andi/ori, beq)
// with on-chip IMEM (64 x 32) and DMEM (32 x 64). The datapath lives here;
// sequencing comes from riscv_mc_control. There are no data outputs: the
// state, PC, register file and memories are inspected hierarchically, and
// IMEM/DMEM are preloaded the same way (reset does not clear them).
// Ports:
//   clk    clock, all state updates on the rising edge
//   reset  asynchronous active-low reset
//   run    level request to start execution (sampled in START)
//   power  level enable (sampled in START)
module riscv_multicycle_core
    import riscv_mc_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic power
);

    logic [31:0]     imem [IMEM_WORDS];
    logic [XLEN-1:0] dmem [DMEM_WORDS];
    logic [XLEN-1:0] regs [NUM_REGS];

    logic [7:0]      pc_reg;
    logic [31:0]     ir_reg;
    logic [XLEN-1:0] dmem_rdata_reg;

    logic [3:0]      state;
    logic            startpc, writepc, alusrc, memread, memwrite;
    logic            regwrite, mem2reg, pcsrc;
    logic [1:0]      alu_op;

    logic [31:0]     fetch_instr;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic [XLEN-1:0] imm_i, imm_s, imm_sel;
    logic [7:0]      branch_off;
    logic [XLEN-1:0] alu_b, alu_result, wb_data;
    logic            alu_zero;
    logic [NUM_REGS-1:0] rf_we;

    riscv_mc_control u_control (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .power       (power),
        .fetch_instr (fetch_instr),
        .instr       (ir_reg),
        .alu_zero    (alu_zero),
        .state       (state),
        .startpc     (startpc),
        .writepc     (writepc),
        .alusrc      (alusrc),
        .alu_op      (alu_op),
        .memread     (memread),
        .memwrite    (memwrite),
        .regwrite    (regwrite),
        .mem2reg     (mem2reg),
        .pcsrc       (pcsrc)
    );

    assign fetch_instr = imem[pc_reg[7:2]];
    assign rs1         = ir_reg[19:15];
    assign rs2         = ir_reg[24:20];
    assign rd          = ir_reg[11:7];

    assign imm_i   = {{52{ir_reg[31]}}, ir_reg[31:20]};
    assign imm_s   = {{52{ir_reg[31]}}, ir_reg[31:25], ir_reg[11:7]};
    assign imm_sel = (ir_reg[6:0] == OP_STORE) ? imm_s : imm_i;
    // PC is only 8 bits wide, so only B-immediate bits [7:0] matter.
    assign branch_off = {ir_reg[27:25], ir_reg[11:8], 1'b0};

    assign rs1_data = regs[rs1];
    assign rs2_data = regs[rs2];
    assign alu_b    = alusrc ? imm_sel : rs2_data;

    always_comb begin
        alu_result = rs1_data + alu_b;
        case (alu_op)
            ALU_SUB: alu_result = rs1_data - alu_b;
            ALU_AND: alu_result = rs1_data & alu_b;
            ALU_OR:  alu_result = rs1_data | alu_b;
            default: alu_result = rs1_data + alu_b;
        endcase
    end

    assign alu_zero = (alu_result == '0);
    assign wb_data  = mem2reg ? dmem_rdata_reg : alu_result;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg <= '0;
        end else if (writepc) begin
            if (startpc)
                pc_reg <= '0;
            else if (pcsrc)
                pc_reg <= pc_reg + branch_off;
            else
                pc_reg <= pc_reg + 8'd4;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ir_reg <= '0;
        else if (state == FETCH)
            ir_reg <= fetch_instr;
    end

    // x0 never gets a write enable, so it stays at its reset value of 0.
    assign rf_we[0] = 1'b0;
    genvar gi;
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_rf_we
        assign rf_we[gi] = regwrite && (rd == 5'(gi));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                if (rf_we[i])
                    regs[i] <= wb_data;
        end
    end

    // DMEM keeps its contents across reset; memwrite is cleared
    // asynchronously, so an aborted store never commits.
    always_ff @(posedge clk) begin
        if (memwrite)
            dmem[alu_result[7:3]] <= rs2_data;
        if (memread)
            dmem_rdata_reg <= dmem[alu_result[7:3]];
    end

endmodule

// File: tb/tb_riscv_multicycle_core.sv
module tb_riscv_multicycle_core;
    import riscv_mc_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic run = 1'b0;
    logic power = 1'b0;

    always #5 clk = ~clk;

    riscv_multicycle_core dut (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .power (power)
    );

    int errors = 0;
    int checks = 0;

    // Scoreboard: kind 0 = register, 1 = DMEM word
    string       sb_tag_q[$];
    int          sb_kind_q[$];
    int          sb_idx_q[$];
    logic [63:0] sb_val_q[$];
    int          lat_q[$];
    logic [63:0] pc_q[$];
    logic [31:0] prog[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: got=0x%0h", tag, got);
        end
    endtask

    function automatic logic [31:0] enc_ld(int rd, int rs1, int imm);
        logic [11:0] i = 12'(imm);
        return {i, 5'(rs1), 3'b011, 5'(rd), 7'b0000011};
    endfunction

    function automatic logic [31:0] enc_sd(int rs2, int rs1, int imm);
        logic [11:0] i = 12'(imm);
        return {i[11:5], 5'(rs2), 5'(rs1), 3'b011, i[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_i(int f3, int rd, int rs1, int imm);
        logic [11:0] i = 12'(imm);
        return {i, 5'(rs1), 3'(f3), 5'(rd), 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_r(int f7, int f3, int rd, int rs1, int rs2);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_beq(int rs1, int rs2, int imm);
        logic [12:0] b = 13'(imm);
        return {b[12], b[10:5], 5'(rs2), 5'(rs1), 3'b000, b[4:1], b[11], 7'b1100011};
    endfunction

    function automatic logic [63:0] observe(int kind, int idx);
        if (kind == 0)
            return dut.regs[idx];
        return dut.dmem[idx];
    endfunction

    task automatic expect_val(input string tag, input int kind, input int idx, input logic [63:0] v);
        sb_tag_q.push_back(tag);
        sb_kind_q.push_back(kind);
        sb_idx_q.push_back(idx);
        sb_val_q.push_back(v);
    endtask

    task automatic drain_scoreboard();
        while (sb_tag_q.size() > 0) begin
            string t = sb_tag_q.pop_front();
            int k = sb_kind_q.pop_front();
            int x = sb_idx_q.pop_front();
            logic [63:0] v = sb_val_q.pop_front();
            check(t, observe(k, x), v);
        end
    endtask

    task automatic load_program();
        for (int i = 0; i < 64; i++)
            dut.imem[i] = 32'd0;
        for (int i = 0; i < prog.size(); i++)
            dut.imem[i] = prog[i];
        prog.delete();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        run   = 1'b0;
        power = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Runs from START until HALT, checking fetch-to-fetch latency and PC at
    // each new FETCH against the queued expectations, then drains results.
    task automatic run_program(input string name, input int budget);
        int cyc = 0;
        int last = -1;
        bit halted = 1'b0;
        @(negedge clk);
        run   = 1'b1;
        power = 1'b1;
        while (cyc < budget && !halted) begin
            @(negedge clk);
            cyc++;
            if (dut.u_control.state_reg == FETCH) begin
                if (last >= 0) begin
                    if (lat_q.size() > 0)
                        check({name, " latency"}, 64'(cyc - last), 64'(lat_q.pop_front()));
                    else
                        check({name, " extra fetch"}, 64'(cyc - last), 64'd0);
                    if (pc_q.size() > 0)
                        check({name, " pc"}, 64'(dut.pc_reg), pc_q.pop_front());
                end
                last = cyc;
            end
            if (dut.u_control.state_reg == HALT)
                halted = 1'b1;
        end
        run   = 1'b0;
        power = 1'b0;
        check({name, " halted"}, 64'(halted), 64'd1);
        check({name, " fetches left"}, 64'(lat_q.size()), 64'd0);
        lat_q.delete();
        pc_q.delete();
        drain_scoreboard();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        state_t seq[8] = '{DECODE, LOAD_STORE, LOAD, LOAD_DONE, LOAD_IDLE, FETCH, DECODE, HALT};

        // ---------------- reset, power gating, single ld trace ----------------
        prog.push_back(enc_ld(15, 0, 8));
        load_program();
        dut.dmem[1] <= 64'd25;
        do_reset();
        reset = 1'b0;
        check("reset state", 64'(dut.u_control.state_reg), 64'(START));
        check("reset pc", 64'(dut.pc_reg), 64'd0);
        check("reset writepc", 64'(dut.u_control.writepc), 64'd0);
        check("reset r15", dut.regs[15], 64'd0);
        reset = 1'b1;
        run   = 1'b1;
        power = 1'b0;
        repeat (20) @(negedge clk);
        check("power=0 stays START", 64'(dut.u_control.state_reg), 64'(START));
        check("START startpc", 64'(dut.u_control.startpc), 64'd1);
        power = 1'b1;
        @(negedge clk);
        check("START->FETCH", 64'(dut.u_control.state_reg), 64'(FETCH));
        check("first fetch pc", 64'(dut.pc_reg), 64'd0);
        run   = 1'b0;
        power = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("ld seq%0d", i), 64'(dut.u_control.state_reg), 64'(seq[i]));
            if (i == 1) check("ld alu_result", dut.alu_result, 64'd8);
            if (i == 4) check("ld r15 at LOAD_IDLE", dut.regs[15], 64'd25);
            if (i == 5) check("ld next pc", 64'(dut.pc_reg), 64'd4);
        end

        // ---------------- ld / addi / sd program ----------------
        do_reset();
        prog.push_back(enc_ld(15, 0, 8));
        prog.push_back(enc_i(0, 5, 15, -3));
        prog.push_back(enc_sd(5, 0, 88));
        load_program();
        dut.dmem[11] <= 64'd0;
        lat_q = '{6, 4, 4};
        expect_val("mem r15", 0, 15, 64'd25);
        expect_val("mem r5", 0, 5, 64'd22);
        expect_val("mem dmem11", 1, 11, 64'd22);
        run_program("mem", 200);

        // ---------------- ALU program ----------------
        do_reset();
        prog.push_back(enc_i(0, 1, 0, 'hF0));
        prog.push_back(enc_i(0, 2, 0, 'h3C));
        prog.push_back(enc_r(0, 0, 3, 1, 2));
        prog.push_back(enc_r('h20, 0, 4, 1, 2));
        prog.push_back(enc_r(0, 7, 5, 1, 2));
        prog.push_back(enc_r(0, 6, 6, 1, 2));
        prog.push_back(enc_i(0, 8, 0, 1));
        prog.push_back(enc_r('h20, 0, 9, 0, 8));
        prog.push_back(enc_i(7, 10, 1, 'h3C));
        prog.push_back(enc_i(6, 11, 1, 'h0F));
        prog.push_back(enc_i(0, 0, 0, 5));
        prog.push_back(32'h0000007F);
        prog.push_back(enc_i(0, 12, 0, -1));
        prog.push_back(enc_r(0, 4, 13, 1, 2));
        load_program();
        for (int i = 0; i < 11; i++) lat_q.push_back(4);
        lat_q.push_back(2);
        lat_q.push_back(4);
        lat_q.push_back(4);
        expect_val("alu add", 0, 3, 64'h12C);
        expect_val("alu sub", 0, 4, 64'hB4);
        expect_val("alu and", 0, 5, 64'h30);
        expect_val("alu or", 0, 6, 64'hFC);
        expect_val("alu 0-1", 0, 9, 64'hFFFF_FFFF_FFFF_FFFF);
        expect_val("alu andi", 0, 10, 64'h30);
        expect_val("alu ori", 0, 11, 64'hFF);
        expect_val("alu x0", 0, 0, 64'd0);
        expect_val("alu addi -1", 0, 12, 64'hFFFF_FFFF_FFFF_FFFF);
        expect_val("alu funct fallback", 0, 13, 64'h12C);
        run_program("alu", 400);

        // ---------------- beq taken ----------------
        do_reset();
        prog.push_back(enc_beq(0, 0, 8));
        prog.push_back(enc_i(0, 1, 0, 1));
        prog.push_back(enc_i(0, 2, 0, 2));
        load_program();
        lat_q = '{4, 4};
        pc_q  = '{64'd8, 64'd12};
        expect_val("beq taken skipped x1", 0, 1, 64'd0);
        expect_val("beq taken x2", 0, 2, 64'd2);
        run_program("beq taken", 200);

        // ---------------- beq not taken ----------------
        do_reset();
        prog.push_back(enc_i(0, 1, 0, 1));
        prog.push_back(enc_beq(1, 0, 8));
        prog.push_back(enc_i(0, 2, 0, 2));
        load_program();
        lat_q = '{4, 4, 4};
        pc_q  = '{64'd4, 64'd8, 64'd12};
        expect_val("beq not taken x2", 0, 2, 64'd2);
        run_program("beq not taken", 200);

        // ---------------- backward branch wraps PC ----------------
        do_reset();
        prog.push_back(enc_beq(0, 0, -4));
        load_program();
        lat_q = '{4};
        pc_q  = '{64'hFC};
        run_program("beq wrap", 200);

        // ---------------- reset during LOAD ----------------
        do_reset();
        prog.push_back(enc_ld(15, 0, 8));
        load_program();
        begin
            int cyc = 0;
            @(negedge clk);
            run   = 1'b1;
            power = 1'b1;
            while (cyc < 20 && dut.u_control.state_reg != LOAD) begin
                @(negedge clk);
                cyc++;
            end
            check("abort reached LOAD", 64'(dut.u_control.state_reg), 64'(LOAD));
            reset = 1'b0;
            run   = 1'b0;
            power = 1'b0;
            #1;
            check("abort state", 64'(dut.u_control.state_reg), 64'(START));
            check("abort pc", 64'(dut.pc_reg), 64'd0);
            repeat (3) @(negedge clk);
            check("abort r15", dut.regs[15], 64'd0);
            reset = 1'b1;
            repeat (3) @(negedge clk);
            check("abort idle state", 64'(dut.u_control.state_reg), 64'(START));
            check("abort idle r15", dut.regs[15], 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
